// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential signed multiplier.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

    // Widest operand supported by sat_frac. Callers sign-extend into this width.
    localparam int MAX_N  = 64;
    localparam int PROD_W = 2 * MAX_N;

    // Q1.(n-1) result from a 2n-bit product sign-extended to PROD_W.
    // -1 x -1 gives +1.0, which the format cannot hold, so that result
    // clamps to the largest positive value. All other products are truncated
    // toward minus infinity.
    function automatic logic [MAX_N-1:0] sat_frac(input logic [PROD_W-1:0] prod, input int n);
        logic [PROD_W-1:0] most_neg_sq;
        most_neg_sq          = '0;
        most_neg_sq[2*n-2]   = 1'b1;
        if (prod == most_neg_sq)
            sat_frac = (MAX_N'(1) << (n - 1)) - MAX_N'(1);
        else
            sat_frac = MAX_N'(prod >> (n - 1));
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: operand magnitudes, accumulator, sign fix-up and
// saturated fractional output.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic           last,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    output logic [n-1:0]   result,
    output logic [2*n-1:0] prod
);

    logic [2*n-1:0] mcand;
    logic [n-1:0]   mplier;
    logic           sign;
    logic [2*n-1:0] acc;

    logic [n-1:0]   mag_a;
    logic [n-1:0]   mag_b;
    logic [2*n-1:0] acc_sum;
    logic [2*n-1:0] prod_next;
    logic [n-1:0]   result_next;

    // Magnitudes, next partial sum, signed product and its saturated fraction.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path; assigning defaults first rules out inferred latches.
        mag_a       = a;
        mag_b       = b;
        acc_sum     = acc;
        prod_next   = '0;
        result_next = '0;
        // |-2^(n-1)| = 2^(n-1) still fits as an n-bit unsigned magnitude.
        if (a[n-1]) mag_a = -a;
        if (b[n-1]) mag_b = -b;
        if (mplier[0]) acc_sum = acc + mcand;
        prod_next   = sign ? -acc_sum : acc_sum;
        result_next = n'(sat_frac(PROD_W'($signed(prod_next)), n));
    end

    // Operand latch on accept, one shift-add per RUN step, output update on the last step.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every register here is a handful of flops, not a RAM, so all of them are cleared on reset and no stale product survives it.
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            sign   <= 1'b0;
            acc    <= '0;
            prod   <= '0;
            result <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values; blocking here would chain the updates within one edge.
            mcand  <= {{n{1'b0}}, mag_a};
            mplier <= mag_b;
            sign   <= a[n-1] ^ b[n-1];
            acc    <= '0;
        end else if (step) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (last) begin
                prod   <= prod_next;
                result <= result_next;
            end
        end
    end

endmodule

// File: rtl/seq_mult.sv
// Sequential signed multiplier: control FSM and step counter around the
// shift-add datapath. busy/done decode directly from the state register.
module seq_mult
    import mult_pkg::*;
#(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [n-1:0]   result,
    output logic [2*n-1:0] prod
);

    localparam int CW = $clog2(n) + 1;

    mult_state_t   state;
    mult_state_t   state_next;
    logic [CW-1:0] cnt;
    logic          load;
    logic          step;
    logic          last;

    assign last = (cnt == CW'(n - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register and step counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (load)
                cnt <= '0;
            else if (step)
                cnt <= cnt + 1'b1;
        end
    end

    // Next-state and datapath strobes; start is only honoured in IDLE and DONE.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    mult_datapath #(.n(n)) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .last   (last),
        .a      (a),
        .b      (b),
        .result (result),
        .prod   (prod)
    );

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult (n = 8).
module tb_seq_mult;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [7:0]  result;
    logic [15:0] prod;

    int n_checks = 0;
    int n_fail   = 0;

    seq_mult #(.n(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .prod   (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One operation from an idle start: reports latency (start cycle counted
    // as cycle 1, -1 on timeout), idle-cycle gaps in busy, busy&done overlaps.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          output int lat, output int gaps, output int overlap,
                          output logic [15:0] p, output logic [7:0] r);
        bit seen;
        seen    = 0;
        lat     = 0;
        gaps    = 0;
        overlap = 0;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (busy && done) overlap++;
            if (done) begin
                seen = 1;
                break;
            end
            if (!busy) gaps++;
        end
        if (!seen) lat = -1;
        p = prod;
        r = result;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result got %h want 00", result); end
        if (prod !== 16'h0000) begin n_fail++; $display("FAIL reset_prod got %h want 0000", prod); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat, gaps, ov; logic [15:0] p; logic [7:0] r;
        run_op(8'h40, 8'h40, lat, gaps, ov, p, r);
        n_checks += 5;
        if (lat !== 9) begin n_fail++; $display("FAIL basic_latency got %0d want 9", lat); end
        if (gaps !== 0) begin n_fail++; $display("FAIL basic_busy_gaps got %0d want 0", gaps); end
        if (ov !== 0) begin n_fail++; $display("FAIL basic_overlap got %0d want 0", ov); end
        if (p !== 16'h1000) begin n_fail++; $display("FAIL basic_prod got %h want 1000", p); end
        if (r !== 8'h20) begin n_fail++; $display("FAIL basic_result got %h want 20", r); end
    endtask

    task automatic test_saturate();
        int lat, gaps, ov; logic [15:0] p; logic [7:0] r;
        run_op(8'h80, 8'h80, lat, gaps, ov, p, r);
        n_checks += 2;
        if (p !== 16'h4000) begin n_fail++; $display("FAIL sat_prod got %h want 4000", p); end
        if (r !== 8'h7F) begin n_fail++; $display("FAIL sat_result got %h want 7f", r); end
    endtask

    task automatic test_negative();
        int lat, gaps, ov; logic [15:0] p; logic [7:0] r;
        run_op(8'h80, 8'h40, lat, gaps, ov, p, r);
        n_checks += 2;
        if (p !== 16'hE000) begin n_fail++; $display("FAIL neg1_prod got %h want e000", p); end
        if (r !== 8'hC0) begin n_fail++; $display("FAIL neg1_result got %h want c0", r); end
        run_op(8'hFF, 8'h03, lat, gaps, ov, p, r);
        n_checks += 3;
        if (lat !== 9) begin n_fail++; $display("FAIL neg2_latency got %0d want 9", lat); end
        if (p !== 16'hFFFD) begin n_fail++; $display("FAIL neg2_prod got %h want fffd", p); end
        if (r !== 8'hFF) begin n_fail++; $display("FAIL neg2_result got %h want ff", r); end
    endtask

    task automatic test_start_in_run();
        int ndone; logic [15:0] p; logic [7:0] r;
        ndone = 0; p = '0; r = '0;
        @(negedge clk);
        a = 8'h30; b = 8'h20; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 4) begin
                start = 1'b1; a = 8'h7F; b = 8'h7F;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                if (ndone == 0) begin p = prod; r = result; end
                ndone++;
            end
            @(posedge clk);
        end
        n_checks += 3;
        if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        if (p !== 16'h0600) begin n_fail++; $display("FAIL ignore_prod got %h want 0600", p); end
        if (r !== 8'h0C) begin n_fail++; $display("FAIL ignore_result got %h want 0c", r); end
    endtask

    task automatic test_back_to_back();
        int cyc, first, second, ov;
        logic busy_after; logic [15:0] p1, p2; logic [7:0] r2;
        cyc = 0; first = -1; second = -1; ov = 0; busy_after = 1'b0;
        p1 = '0; p2 = '0; r2 = '0;
        @(negedge clk);
        a = 8'h10; b = 8'h10; start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (busy && done) ov++;
            if (first < 0) begin
                if (done) begin
                    first = cyc; p1 = prod;
                    a = 8'hF0; b = 8'h20;
                end
            end else if (cyc == first + 1) begin
                busy_after = busy;
                start = 1'b0;
            end else if (done) begin
                second = cyc; p2 = prod; r2 = result;
                break;
            end
        end
        start = 1'b0;
        n_checks += 6;
        if (p1 !== 16'h0100) begin n_fail++; $display("FAIL b2b_prod1 got %h want 0100", p1); end
        if (busy_after !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_next got %b want 1", busy_after); end
        if ((first < 0) || (second < 0) || (second - first != 9)) begin
            n_fail++; $display("FAIL b2b_gap got %0d want 9", second - first);
        end
        if (p2 !== 16'hFE00) begin n_fail++; $display("FAIL b2b_prod2 got %h want fe00", p2); end
        if (r2 !== 8'hFC) begin n_fail++; $display("FAIL b2b_result2 got %h want fc", r2); end
        if (ov !== 0) begin n_fail++; $display("FAIL b2b_overlap got %0d want 0", ov); end
    endtask

    task automatic test_reset_mid_run();
        int ndone, lat, gaps, ov; logic [15:0] p; logic [7:0] r;
        ndone = 0;
        @(negedge clk);
        a = 8'h40; b = 8'h40; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstrun_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL rstrun_done got %b want 0", done); end
        if (prod !== 16'h0000) begin n_fail++; $display("FAIL rstrun_prod got %h want 0000", prod); end
        if (result !== 8'h00) begin n_fail++; $display("FAIL rstrun_result got %h want 00", result); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_checks += 1;
        if (ndone !== 0) begin n_fail++; $display("FAIL rstrun_spurious_done got %0d want 0", ndone); end
        run_op(8'h7F, 8'h02, lat, gaps, ov, p, r);
        n_checks += 3;
        if (lat !== 9) begin n_fail++; $display("FAIL rstrun_latency got %0d want 9", lat); end
        if (p !== 16'h00FE) begin n_fail++; $display("FAIL rstrun_prod2 got %h want 00fe", p); end
        if (r !== 8'h01) begin n_fail++; $display("FAIL rstrun_result2 got %h want 01", r); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_negative();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
